// File: rtl/uart_cfg_pkg.sv
// uart_cfg_pkg: shared constants and FSM state encodings for uart_cfg.
// Rev 1.0
`default_nettype none
package uart_cfg_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  localparam int OS_TICKS = 16;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;
endpackage
`default_nettype wire

// File: rtl/uart_fifo_fwft.sv
// uart_fifo_fwft: first-word-fall-through FIFO with 2^AW entries.
// Rev 1.0
`default_nettype none
module uart_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic             r_full, r_empty;
  logic             w_do_rd, w_do_wr;
  logic [AW-1:0]    w_wptr_inc, w_rptr_inc;

  // A read frees the slot a simultaneous write needs, so full does not block it.
  assign w_do_rd    = rd & ~r_empty;
  assign w_do_wr    = wr & (~r_full | w_do_rd);
  assign w_wptr_inc = r_wptr + 1'b1;
  assign w_rptr_inc = r_rptr + 1'b1;

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_do_wr) r_wptr <= w_wptr_inc;
      if (w_do_rd) r_rptr <= w_rptr_inc;
      if (w_do_wr && !w_do_rd) begin
        r_empty <= 1'b0;
        r_full  <= (w_wptr_inc == r_rptr);
      end else if (w_do_rd && !w_do_wr) begin
        r_full  <= 1'b0;
        r_empty <= (w_rptr_inc == r_wptr);
      end
    end
  end

  assign rd_data = r_empty ? '0 : r_mem[r_rptr];
  assign full    = r_full;
  assign empty   = r_empty;
endmodule
`default_nettype wire

// File: rtl/uart_cfg.sv
// uart_cfg: full-duplex UART, runtime baud divisor, optional parity, RX error flags.
// Rev 1.0
`default_nettype none
module uart_cfg
  import uart_cfg_pkg::*;
#(
  parameter int DBITS     = 8,
  parameter int PARITY    = 0,
  parameter int SB_TICKS  = 16,
  parameter int FIFO_AW   = 4,
  parameter int DVSR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DVSR_BITS-1:0] dvsr,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 wr_uart,
  input  logic [DBITS-1:0]     wr_data,
  output logic                 tx_full,
  output logic                 tx_empty,
  input  logic                 rd_uart,
  output logic [DBITS-1:0]     rd_data,
  output logic                 rd_perr,
  output logic                 rd_ferr,
  output logic                 rx_empty,
  output logic                 overrun,
  input  logic                 clr_err
);
  localparam logic [4:0] c_MID      = 5'd7;
  localparam logic [4:0] c_BIT_END  = 5'(OS_TICKS - 1);
  localparam logic [4:0] c_STOP_END = 5'(SB_TICKS - 1);
  localparam logic [2:0] c_LAST_BIT = 3'(DBITS - 1);
  localparam logic       c_HAS_PAR  = (PARITY != PAR_NONE);

  logic [DVSR_BITS-1:0] r_tcnt;
  logic                 w_tick;

  assign w_tick = (r_tcnt >= dvsr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_tcnt <= '0;
    else       r_tcnt <= w_tick ? '0 : r_tcnt + 1'b1;
  end

  // ---------------- receiver ----------------
  logic             r_rx_meta, r_rx_sync;
  rx_state_t        r_rx_state, w_rx_state_nxt;
  logic [4:0]       r_rx_s, w_rx_s_nxt;
  logic [2:0]       r_rx_n, w_rx_n_nxt;
  logic [DBITS-1:0] r_rx_b, w_rx_b_nxt;
  logic             r_rx_perr, w_rx_perr_nxt;
  logic             w_rx_push, w_rx_full, r_overrun;
  logic [DBITS+1:0] w_rx_head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_s     <= '0;
      r_rx_n     <= '0;
      r_rx_b     <= '0;
      r_rx_perr  <= 1'b0;
    end else begin
      r_rx_meta  <= rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_state <= w_rx_state_nxt;
      r_rx_s     <= w_rx_s_nxt;
      r_rx_n     <= w_rx_n_nxt;
      r_rx_b     <= w_rx_b_nxt;
      r_rx_perr  <= w_rx_perr_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_s_nxt     = r_rx_s;
    w_rx_n_nxt     = r_rx_n;
    w_rx_b_nxt     = r_rx_b;
    w_rx_perr_nxt  = r_rx_perr;
    w_rx_push      = 1'b0;
    case (r_rx_state)
      RX_IDLE: if (!r_rx_sync) begin
        w_rx_state_nxt = RX_START;
        w_rx_s_nxt     = '0;
        w_rx_perr_nxt  = 1'b0;
      end
      RX_START: if (w_tick) begin
        if (r_rx_s == c_MID) begin
          if (r_rx_sync) begin
            w_rx_state_nxt = RX_IDLE;
          end else begin
            w_rx_state_nxt = RX_DATA;
            w_rx_s_nxt     = '0;
            w_rx_n_nxt     = '0;
          end
        end else w_rx_s_nxt = r_rx_s + 5'd1;
      end
      RX_DATA: if (w_tick) begin
        if (r_rx_s == c_BIT_END) begin
          w_rx_s_nxt = '0;
          w_rx_b_nxt = {r_rx_sync, r_rx_b[DBITS-1:1]};
          if (r_rx_n == c_LAST_BIT) w_rx_state_nxt = c_HAS_PAR ? RX_PARITY : RX_STOP;
          else                      w_rx_n_nxt     = r_rx_n + 3'd1;
        end else w_rx_s_nxt = r_rx_s + 5'd1;
      end
      RX_PARITY: if (w_tick) begin
        if (r_rx_s == c_BIT_END) begin
          w_rx_s_nxt     = '0;
          w_rx_state_nxt = RX_STOP;
          w_rx_perr_nxt  = (PARITY == PAR_ODD) ? ~((^r_rx_b) ^ r_rx_sync)
                                               : ((^r_rx_b) ^ r_rx_sync);
        end else w_rx_s_nxt = r_rx_s + 5'd1;
      end
      RX_STOP: if (w_tick) begin
        if (r_rx_s == c_STOP_END) begin
          w_rx_push      = 1'b1;
          w_rx_state_nxt = RX_IDLE;
        end else w_rx_s_nxt = r_rx_s + 5'd1;
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  uart_fifo_fwft #(.WIDTH(DBITS + 2), .AW(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (w_rx_push),
    .wr_data ({~r_rx_sync, r_rx_perr, r_rx_b}),
    .rd      (rd_uart),
    .rd_data (w_rx_head),
    .full    (w_rx_full),
    .empty   (rx_empty)
  );

  // A pop in the same cycle makes room, so the word is only lost without one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                r_overrun <= 1'b0;
    else if (w_rx_push && w_rx_full && !rd_uart) r_overrun <= 1'b1;
    else if (clr_err)                         r_overrun <= 1'b0;
  end

  assign rd_data = w_rx_head[DBITS-1:0];
  assign rd_perr = w_rx_head[DBITS];
  assign rd_ferr = w_rx_head[DBITS+1];
  assign overrun = r_overrun;

  // ---------------- transmitter ----------------
  tx_state_t        r_tx_state, w_tx_state_nxt;
  logic [4:0]       r_tx_s, w_tx_s_nxt;
  logic [2:0]       r_tx_n, w_tx_n_nxt;
  logic [DBITS-1:0] r_tx_b, w_tx_b_nxt;
  logic             r_tx_par, w_tx_par_nxt;
  logic             r_tx, w_tx_nxt;
  logic             w_tx_pop, w_txf_empty, w_tx_par_head;
  logic [DBITS-1:0] w_tx_head;

  assign w_tx_par_head = (PARITY == PAR_ODD) ? ~(^w_tx_head) : (^w_tx_head);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_s     <= '0;
      r_tx_n     <= '0;
      r_tx_b     <= '0;
      r_tx_par   <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_s     <= w_tx_s_nxt;
      r_tx_n     <= w_tx_n_nxt;
      r_tx_b     <= w_tx_b_nxt;
      r_tx_par   <= w_tx_par_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_s_nxt     = r_tx_s;
    w_tx_n_nxt     = r_tx_n;
    w_tx_b_nxt     = r_tx_b;
    w_tx_par_nxt   = r_tx_par;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      TX_IDLE: if (!w_txf_empty) begin
        w_tx_pop       = 1'b1;
        w_tx_b_nxt     = w_tx_head;
        w_tx_par_nxt   = w_tx_par_head;
        w_tx_s_nxt     = '0;
        w_tx_state_nxt = TX_START;
      end
      TX_START: if (w_tick) begin
        if (r_tx_s == c_BIT_END) begin
          w_tx_s_nxt     = '0;
          w_tx_n_nxt     = '0;
          w_tx_state_nxt = TX_DATA;
        end else w_tx_s_nxt = r_tx_s + 5'd1;
      end
      TX_DATA: if (w_tick) begin
        if (r_tx_s == c_BIT_END) begin
          w_tx_s_nxt = '0;
          w_tx_b_nxt = r_tx_b >> 1;
          if (r_tx_n == c_LAST_BIT) w_tx_state_nxt = c_HAS_PAR ? TX_PARITY : TX_STOP;
          else                      w_tx_n_nxt     = r_tx_n + 3'd1;
        end else w_tx_s_nxt = r_tx_s + 5'd1;
      end
      TX_PARITY: if (w_tick) begin
        if (r_tx_s == c_BIT_END) begin
          w_tx_s_nxt     = '0;
          w_tx_state_nxt = TX_STOP;
        end else w_tx_s_nxt = r_tx_s + 5'd1;
      end
      TX_STOP: if (w_tick) begin
        if (r_tx_s == c_STOP_END) begin
          // Chain straight into the next queued word so frames stay contiguous.
          w_tx_s_nxt = '0;
          if (!w_txf_empty) begin
            w_tx_pop       = 1'b1;
            w_tx_b_nxt     = w_tx_head;
            w_tx_par_nxt   = w_tx_par_head;
            w_tx_state_nxt = TX_START;
          end else w_tx_state_nxt = TX_IDLE;
        end else w_tx_s_nxt = r_tx_s + 5'd1;
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
    case (w_tx_state_nxt)
      TX_START:  w_tx_nxt = 1'b0;
      TX_DATA:   w_tx_nxt = w_tx_b_nxt[0];
      TX_PARITY: w_tx_nxt = w_tx_par_nxt;
      default:   w_tx_nxt = 1'b1;
    endcase
  end

  uart_fifo_fwft #(.WIDTH(DBITS), .AW(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr_uart),
    .wr_data (wr_data),
    .rd      (w_tx_pop),
    .rd_data (w_tx_head),
    .full    (tx_full),
    .empty   (w_txf_empty)
  );

  assign tx       = r_tx;
  assign tx_empty = w_txf_empty & (r_tx_state == TX_IDLE);
endmodule
`default_nettype wire
